// File: rtl/riffa_sg_pkg.sv
// riffa_sg_pkg: scatter-gather record geometry and list-writer state encoding.
package riffa_sg_pkg;
    localparam int SG_ELEM_WORDS = 3;
    localparam int SG_BEAT_WORDS = 4;
    typedef enum logic [1:0] {IDLE, RUN, FLUSH} sg_state_t;
endpackage

// File: rtl/sg_list_writer_128.sv
// sg_list_writer_128: packs 3-word SG elements densely into 128-bit engine beats.
// Optional SG_LIST_WRITER_WORD_COUNT_EN adds a per-list emitted word counter output.
module sg_list_writer_128
    import riffa_sg_pkg::*;
#(
    parameter int C_DATA_WIDTH = 128,
    parameter int C_DATA_WORD_WIDTH = 3
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         ELEM_VALID,
    input  logic [63:0]                  ELEM_ADDR,
    input  logic [31:0]                  ELEM_LEN,
    input  logic                         ELEM_LAST,
    output logic                         ELEM_RDY,
    input  logic                         ABORT,
`ifdef SG_LIST_WRITER_WORD_COUNT_EN
    output logic [31:0]                  WORD_COUNT,
`endif
    output logic [C_DATA_WIDTH-1:0]      DATA,
    output logic [C_DATA_WORD_WIDTH-1:0] DATA_EN,
    output logic                         DONE,
    output logic                         ERR
);
    sg_state_t rState, n_state;
    logic [1:0] rCnt, n_cnt;
    logic [95:0] rBuf, n_buf;
    logic [191:0] merged;
    logic [2:0] total;
    logic accept, full;
    logic [C_DATA_WIDTH-1:0] n_data;
    logic [C_DATA_WORD_WIDTH-1:0] n_en;
    logic n_done, n_err;

    // New record lands right after the leftover words; unused lanes stay zero.
    always_comb begin
        accept = ELEM_VALID && ELEM_RDY;
        merged = {96'd0, rBuf} | ({96'd0, ELEM_LEN, ELEM_ADDR} << {rCnt, 5'd0});
        total = {1'b0, rCnt} + 3'(SG_ELEM_WORDS);
        full = total >= 3'(SG_BEAT_WORDS);
        n_state = rState;
        n_cnt = rCnt;
        n_buf = rBuf;
        n_data = '0;
        n_en = '0;
        n_done = 1'b0;
        n_err = 1'b0;
        if (ABORT && (rState != IDLE || accept)) begin
            n_state = IDLE;
            n_cnt = '0;
            n_buf = '0;
            n_done = 1'b1;
            n_err = 1'b1;
        end else if (rState == FLUSH) begin
            n_state = IDLE;
            n_cnt = '0;
            n_buf = '0;
            n_data = {32'd0, rBuf};
            n_en = {1'b0, rCnt};
            n_done = 1'b1;
        end else if (accept) begin
            n_data = (full || ELEM_LAST) ? merged[127:0] : '0;
            n_en = full ? 3'(SG_BEAT_WORDS) : (ELEM_LAST ? total : 3'd0);
            n_cnt = full ? 2'(total - 3'(SG_BEAT_WORDS)) : (ELEM_LAST ? 2'd0 : total[1:0]);
            n_buf = full ? {32'd0, merged[191:128]} : (ELEM_LAST ? 96'd0 : merged[95:0]);
            n_done = ELEM_LAST && (total <= 3'(SG_BEAT_WORDS));
            n_state = !ELEM_LAST ? RUN : (total > 3'(SG_BEAT_WORDS) ? FLUSH : IDLE);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rState <= IDLE;
            rCnt <= '0;
            rBuf <= '0;
            DATA <= '0;
            DATA_EN <= '0;
            DONE <= 1'b0;
            ERR <= 1'b0;
            ELEM_RDY <= 1'b0;
        end else begin
            rState <= n_state;
            rCnt <= n_cnt;
            rBuf <= n_buf;
            DATA <= n_data;
            DATA_EN <= n_en;
            DONE <= n_done;
            ERR <= n_err;
            ELEM_RDY <= n_state != FLUSH;
        end
    end

`ifdef SG_LIST_WRITER_WORD_COUNT_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            WORD_COUNT <= '0;
        else
            WORD_COUNT <= ((accept && rState == IDLE) ? 32'd0 : WORD_COUNT) + 32'(n_en);
    end
`endif
endmodule

// File: tb/tb_sg_list_writer_128.sv
// tb_sg_list_writer_128: table vectors, reset/word-count sequences and a queue-model random run.
module tb_sg_list_writer_128;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic ELEM_VALID = 1'b0;
    logic [63:0] ELEM_ADDR = '0;
    logic [31:0] ELEM_LEN = '0;
    logic ELEM_LAST = 1'b0;
    logic ABORT = 1'b0;
    logic ELEM_RDY;
    logic [127:0] DATA;
    logic [2:0] DATA_EN;
    logic DONE, ERR;
`ifdef SG_LIST_WRITER_WORD_COUNT_EN
    logic [31:0] WORD_COUNT;
`endif
    int checks = 0;
    int errors = 0;

    sg_list_writer_128 dut (
        .CLK(CLK), .RST(RST), .ELEM_VALID(ELEM_VALID), .ELEM_ADDR(ELEM_ADDR),
        .ELEM_LEN(ELEM_LEN), .ELEM_LAST(ELEM_LAST), .ELEM_RDY(ELEM_RDY), .ABORT(ABORT),
`ifdef SG_LIST_WRITER_WORD_COUNT_EN
        .WORD_COUNT(WORD_COUNT),
`endif
        .DATA(DATA), .DATA_EN(DATA_EN), .DONE(DONE), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic v; logic [63:0] a; logic [31:0] l; logic la; logic ab;
        logic [2:0] en; logic [127:0] data; logic done; logic err; logic rdy;
    } vec_t;
    vec_t tbl[$];

    function automatic logic [31:0] lo(input int i); return 32'h1000_0000 + 32'(i); endfunction
    function automatic logic [31:0] hi(input int i); return 32'h2000_0000 + 32'(i); endfunction
    function automatic logic [31:0] ln(input int i); return 32'h3000_0000 + 32'(i); endfunction
    function automatic logic [63:0] ad(input int i); return {hi(i), lo(i)}; endfunction
    function automatic logic [127:0] w4(input logic [31:0] a, b, c, d); return {d, c, b, a}; endfunction

    function automatic vec_t mk(input logic v, input logic [63:0] a, input logic [31:0] l,
                                input logic la, input logic ab, input logic [2:0] en,
                                input logic [127:0] data, input logic done, input logic err,
                                input logic rdy);
        vec_t r;
        r.v = v; r.a = a; r.l = l; r.la = la; r.ab = ab;
        r.en = en; r.data = data; r.done = done; r.err = err; r.rdy = rdy;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [63:0] a, input logic [31:0] l,
                         input logic la, input logic ab);
        ELEM_VALID = v; ELEM_ADDR = a; ELEM_LEN = l; ELEM_LAST = la; ABORT = ab;
        @(posedge CLK);
        #1;
        ELEM_VALID = 1'b0; ABORT = 1'b0; ELEM_LAST = 1'b0;
    endtask

    // Reference model: a plain word queue plus list/flush flags.
    logic [31:0] mq[$];
    bit m_active, m_flush, m_rdy;
    logic [31:0] m_wc;
    logic [2:0] m_en;
    logic [127:0] m_data;
    bit m_done, m_err;

    function automatic void model_reset();
        mq.delete(); m_active = 0; m_flush = 0; m_rdy = 0; m_wc = 0;
    endfunction

    function automatic void emit(input int n);
        m_en = 3'(n);
        for (int k = 0; k < n; k++) m_data[32*k +: 32] = mq.pop_front();
    endfunction

    function automatic void model_step(input logic v, input logic [63:0] a, input logic [31:0] l,
                                       input logic la, input logic ab);
        bit acc = v && m_rdy;
        m_en = 0; m_data = '0; m_done = 0; m_err = 0;
        if (acc && !m_active) m_wc = 0;
        if (ab && (m_active || acc)) begin
            mq.delete(); m_active = 0; m_flush = 0; m_done = 1; m_err = 1;
        end else if (m_flush) begin
            emit(mq.size()); m_done = 1; m_active = 0; m_flush = 0;
        end else if (acc) begin
            mq.push_back(a[31:0]); mq.push_back(a[63:32]); mq.push_back(l);
            m_active = 1;
            if (mq.size() >= 4) begin
                emit(4);
                if (la) begin
                    if (mq.size() == 0) begin m_done = 1; m_active = 0; end
                    else m_flush = 1;
                end
            end else if (la) begin
                emit(mq.size()); m_done = 1; m_active = 0;
            end
        end
        m_wc += 32'(m_en);
        m_rdy = !m_flush;
    endfunction

    initial begin
        tbl.push_back(mk(1, 64'h1_2345_6780, 32'h40, 1, 0, 3, w4(32'h23456780, 32'h1, 32'h40, 0), 1, 0, 1));
        tbl.push_back(mk(1, ad(0), ln(0), 0, 0, 0, '0, 0, 0, 1));
        tbl.push_back(mk(1, ad(1), ln(1), 1, 0, 4, w4(lo(0), hi(0), ln(0), lo(1)), 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 2, w4(hi(1), ln(1), 0, 0), 1, 0, 1));
        tbl.push_back(mk(1, ad(2), ln(2), 0, 0, 0, '0, 0, 0, 1));
        tbl.push_back(mk(1, ad(3), ln(3), 0, 0, 4, w4(lo(2), hi(2), ln(2), lo(3)), 0, 0, 1));
        tbl.push_back(mk(1, ad(4), ln(4), 0, 0, 4, w4(hi(3), ln(3), lo(4), hi(4)), 0, 0, 1));
        tbl.push_back(mk(1, ad(5), ln(5), 1, 0, 4, w4(ln(4), lo(5), hi(5), ln(5)), 1, 0, 1));
        tbl.push_back(mk(1, ad(6), ln(6), 0, 0, 0, '0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, '0, 1, 1, 1));
        tbl.push_back(mk(1, ad(7), ln(7), 1, 0, 3, w4(lo(7), hi(7), ln(7), 0), 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, '0, 0, 0, 1));
        tbl.push_back(mk(1, ad(8), ln(8), 0, 0, 0, '0, 0, 0, 1));
        tbl.push_back(mk(1, ad(9), ln(9), 1, 0, 4, w4(lo(8), hi(8), ln(8), lo(9)), 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, '0, 1, 1, 1));
        tbl.push_back(mk(1, ad(10), ln(10), 0, 0, 0, '0, 0, 0, 1));
        tbl.push_back(mk(1, ad(11), ln(11), 1, 0, 4, w4(lo(10), hi(10), ln(10), lo(11)), 0, 0, 0));
        tbl.push_back(mk(1, ad(12), ln(12), 1, 0, 2, w4(hi(11), ln(11), 0, 0), 1, 0, 1));
        tbl.push_back(mk(1, ad(12), ln(12), 1, 0, 3, w4(lo(12), hi(12), ln(12), 0), 1, 0, 1));

        #2;
        chk("rst_data_en", 128'(DATA_EN), 0);
        chk("rst_data", DATA, 0);
        chk("rst_done_err", {DONE, ERR}, 0);
        chk("rst_rdy", 128'(ELEM_RDY), 0);
        @(posedge CLK); #1; RST = 1'b0;
        chk("rdy_before_edge", 128'(ELEM_RDY), 0);
        @(posedge CLK); #1;
        chk("rdy_after_release", 128'(ELEM_RDY), 1);

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].a, tbl[i].l, tbl[i].la, tbl[i].ab);
            chk($sformatf("row%0d_en", i), 128'(DATA_EN), 128'(tbl[i].en));
            chk($sformatf("row%0d_done", i), 128'(DONE), 128'(tbl[i].done));
            chk($sformatf("row%0d_err", i), 128'(ERR), 128'(tbl[i].err));
            chk($sformatf("row%0d_rdy", i), 128'(ELEM_RDY), 128'(tbl[i].rdy));
            if (tbl[i].en != 0) chk($sformatf("row%0d_data", i), DATA, tbl[i].data);
        end

        // Reset in the middle of a list with two words staged.
        drive(1, ad(13), ln(13), 0, 0);
        drive(1, ad(14), ln(14), 0, 0);
        chk("pre_rst_en", 128'(DATA_EN), 4);
        RST = 1'b1;
        #1;
        chk("async_rst_en", 128'(DATA_EN), 0);
        chk("async_rst_data", DATA, 0);
        chk("async_rst_rdy", 128'(ELEM_RDY), 0);
        @(posedge CLK); #1; RST = 1'b0;
        @(posedge CLK); #1;
        chk("post_rst_rdy", 128'(ELEM_RDY), 1);
        drive(1, ad(15), ln(15), 1, 0);
        chk("post_rst_en", 128'(DATA_EN), 3);
        chk("post_rst_data", DATA, w4(lo(15), hi(15), ln(15), 0));
        chk("post_rst_done", 128'(DONE), 1);

`ifdef SG_LIST_WRITER_WORD_COUNT_EN
        drive(1, ad(16), ln(16), 0, 0);
        drive(1, ad(17), ln(17), 0, 0);
        drive(1, ad(18), ln(18), 1, 0);
        drive(0, 0, 0, 0, 0);
        chk("wc_done", 128'(DONE), 1);
        chk("wc_nine", 128'(WORD_COUNT), 9);
        drive(0, 0, 0, 0, 0);
        chk("wc_hold", 128'(WORD_COUNT), 9);
        drive(1, ad(19), ln(19), 1, 0);
        chk("wc_three", 128'(WORD_COUNT), 3);
`endif

        RST = 1'b1;
        @(posedge CLK); #1; RST = 1'b0;
        model_reset();
        for (int c = 0; c < 800; c++) begin
            logic v, la, ab;
            logic [63:0] a;
            logic [31:0] l;
            v = $urandom_range(0, 9) < 7;
            la = $urandom_range(0, 3) == 0;
            ab = $urandom_range(0, 24) == 0;
            a = {$urandom, $urandom};
            l = $urandom;
            model_step(v, a, l, la, ab);
            drive(v, a, l, la, ab);
            chk($sformatf("rnd%0d_en", c), 128'(DATA_EN), 128'(m_en));
            chk($sformatf("rnd%0d_done_err", c), {DONE, ERR}, {m_done, m_err});
            chk($sformatf("rnd%0d_rdy", c), 128'(ELEM_RDY), 128'(m_rdy));
            if (m_en != 0) chk($sformatf("rnd%0d_data", c), DATA, m_data);
`ifdef SG_LIST_WRITER_WORD_COUNT_EN
            chk($sformatf("rnd%0d_wc", c), 128'(WORD_COUNT), 128'(m_wc));
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
